// File: rtl/decode_pipe_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and execute.
// The master side is whoever drives fetch data and the execute-side ready;
// the slave side is the decode stage.
interface decode_pipe_if #(
    parameter int W_CPU = 32,
    parameter int W_CNT = 16
);
    localparam int W_REG    = 5;
    localparam int W_SHAMT  = 5;
    localparam int W_JADDR  = 26;
    localparam int W_FUNCT  = 6;
    localparam int W_PCSRC  = 2;
    localparam int W_MEMCMD = 2;
    localparam int W_ALUSRC = 2;
    localparam int W_REGSRC = 2;

    logic                in_valid;
    logic                in_ready;
    logic [W_CPU-1:0]    inst;
    logic [W_CPU-1:0]    pc_in;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [W_CPU-1:0]    pc_out;
    logic [W_REG-1:0]    wa;
    logic [W_REG-1:0]    ra1;
    logic [W_REG-1:0]    ra2;
    logic                reg_wen;
    logic [W_CPU-1:0]    imm_out;
    logic [W_SHAMT-1:0]  sha;
    logic [W_JADDR-1:0]  addr;
    logic [W_FUNCT-1:0]  alu_op;
    logic [W_PCSRC-1:0]  pc_src;
    logic [W_MEMCMD-1:0] mem_cmd;
    logic [W_ALUSRC-1:0] alu_src;
    logic [W_REGSRC-1:0] reg_src;
    logic [W_CNT-1:0]    stall_cnt;

    modport master (
        output in_valid, inst, pc_in, flush, out_ready,
        input  in_ready, out_valid, pc_out, wa, ra1, ra2, reg_wen, imm_out,
               sha, addr, alu_op, pc_src, mem_cmd, alu_src, reg_src, stall_cnt
    );

    modport slave (
        input  in_valid, inst, pc_in, flush, out_ready,
        output in_ready, out_valid, pc_out, wa, ra1, ra2, reg_wen, imm_out,
               sha, addr, alu_op, pc_src, mem_cmd, alu_src, reg_src, stall_cnt
    );
endinterface

// File: rtl/decode_pipe.sv
// Registered MIPS instruction-decode stage: single-entry valid/ready pipeline
// register holding the decoded control fields, with load-use bubble insertion,
// flush, and a saturating count of bubble cycles.
module decode_pipe #(
    parameter int W_CPU          = 32,
    parameter int W_CNT          = 16,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    decode_pipe_if.slave bus
);
    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    // Funct / ALU operations
    localparam logic [5:0] F_SLL     = 6'h00;
    localparam logic [5:0] F_SRL     = 6'h02;
    localparam logic [5:0] F_SRA     = 6'h03;
    localparam logic [5:0] F_JR      = 6'h08;
    localparam logic [5:0] F_SYSCALL = 6'h0C;
    localparam logic [5:0] F_ADD     = 6'h20;
    localparam logic [5:0] F_SUB     = 6'h22;
    localparam logic [5:0] F_AND     = 6'h24;
    localparam logic [5:0] F_OR      = 6'h25;
    localparam logic [5:0] F_XOR     = 6'h26;
    localparam logic [5:0] F_SLT     = 6'h2A;
    localparam logic [5:0] F_SLTU    = 6'h2B;
    // Control encodings; all-zero is the safe NOP decode
    localparam logic [1:0] PC_NEXT     = 2'd0;
    localparam logic [1:0] PC_BRCH     = 2'd1;
    localparam logic [1:0] PC_JUMP     = 2'd2;
    localparam logic [1:0] PC_JUMP_REG = 2'd3;
    localparam logic [1:0] MEM_NOP     = 2'd0;
    localparam logic [1:0] MEM_READ    = 2'd1;
    localparam logic [1:0] MEM_WRITE   = 2'd2;
    localparam logic [1:0] ASRC_REG    = 2'd0;
    localparam logic [1:0] ASRC_IMM    = 2'd1;
    localparam logic [1:0] ASRC_SHA    = 2'd2;
    localparam logic [1:0] RSRC_ALU    = 2'd0;
    localparam logic [1:0] RSRC_MEM    = 2'd1;
    localparam logic [1:0] RSRC_PC8    = 2'd2;
    localparam logic [4:0] REG_V0      = 5'd2;
    localparam logic [4:0] REG_A0      = 5'd4;
    localparam logic [4:0] REG_RA      = 5'd31;

    // rt_rd and is_lw are kept alongside the fields so hazard detection
    // works from registered state only.
    typedef struct packed {
        logic [W_CPU-1:0] pc;
        logic [4:0]       wa;
        logic [4:0]       ra1;
        logic [4:0]       ra2;
        logic             reg_wen;
        logic [W_CPU-1:0] imm;
        logic [4:0]       sha;
        logic [25:0]      addr;
        logic [5:0]       alu_op;
        logic [1:0]       pc_src;
        logic [1:0]       mem_cmd;
        logic [1:0]       alu_src;
        logic [1:0]       reg_src;
        logic             rt_rd;
        logic             is_lw;
    } fld_t;

    logic [5:0]       op;
    logic [5:0]       funct;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [W_CPU-1:0] imm_sx;
    logic [W_CPU-1:0] imm_zx;
    fld_t             dec;

    fld_t             fld_d, fld_q;
    logic             held_valid_d, held_valid_q;
    logic             ld_pend_d, ld_pend_q;
    logic [4:0]       ld_wa_d, ld_wa_q;
    logic [W_CNT-1:0] stall_cnt_d, stall_cnt_q;

    logic hazard;
    logic out_valid;
    logic out_fire;
    logic in_ready;
    logic in_fire;

    assign op     = bus.inst[31:26];
    assign rs     = bus.inst[25:21];
    assign rt     = bus.inst[20:16];
    assign rd     = bus.inst[15:11];
    assign funct  = bus.inst[5:0];
    assign imm_sx = {{(W_CPU-16){bus.inst[15]}}, bus.inst[15:0]};
    assign imm_zx = {{(W_CPU-16){1'b0}}, bus.inst[15:0]};

    // Combinational decode of the presented instruction word
    always_comb begin
        dec         = '0;
        dec.pc      = bus.pc_in;
        dec.sha     = bus.inst[10:6];
        dec.addr    = bus.inst[25:0];
        case (op)
            OP_RTYPE: begin
                dec.rt_rd = 1'b1;
                if (funct == F_JR) begin
                    dec.ra1    = rs;
                    dec.pc_src = PC_JUMP_REG;
                end else if (funct == F_SYSCALL) begin
                    dec.ra1 = REG_V0;
                    dec.ra2 = REG_A0;
                end else begin
                    dec.wa      = rd;
                    dec.ra1     = rs;
                    dec.ra2     = rt;
                    dec.reg_wen = 1'b1;
                    dec.alu_op  = funct;
                    if (funct == F_SLL || funct == F_SRL || funct == F_SRA)
                        dec.alu_src = ASRC_SHA;
                    else
                        dec.alu_src = ASRC_REG;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                dec.wa      = rt;
                dec.ra1     = rs;
                dec.ra2     = rt;
                dec.reg_wen = 1'b1;
                dec.alu_src = ASRC_IMM;
                dec.reg_src = RSRC_ALU;
                case (op)
                    OP_SLTI:  begin dec.imm = imm_sx; dec.alu_op = F_SLT;  end
                    OP_SLTIU: begin dec.imm = imm_sx; dec.alu_op = F_SLTU; end
                    OP_ANDI:  begin dec.imm = imm_zx; dec.alu_op = F_AND;  end
                    OP_ORI:   begin dec.imm = imm_zx; dec.alu_op = F_OR;   end
                    OP_XORI:  begin dec.imm = imm_zx; dec.alu_op = F_XOR;  end
                    default:  begin dec.imm = imm_sx; dec.alu_op = F_ADD;  end
                endcase
            end
            OP_BEQ, OP_BNE: begin
                dec.ra1    = rs;
                dec.ra2    = rt;
                dec.imm    = imm_sx;
                dec.alu_op = F_SUB;
                dec.pc_src = PC_BRCH;
                dec.rt_rd  = 1'b1;
            end
            OP_LW: begin
                dec.wa      = rt;
                dec.ra1     = rs;
                dec.ra2     = rt;
                dec.reg_wen = 1'b1;
                dec.imm     = imm_sx;
                dec.alu_op  = F_ADD;
                dec.alu_src = ASRC_IMM;
                dec.mem_cmd = MEM_READ;
                dec.reg_src = RSRC_MEM;
                dec.is_lw   = 1'b1;
            end
            OP_SW: begin
                dec.ra1     = rs;
                dec.ra2     = rt;
                dec.imm     = imm_sx;
                dec.alu_op  = F_ADD;
                dec.alu_src = ASRC_IMM;
                dec.mem_cmd = MEM_WRITE;
                dec.rt_rd   = 1'b1;
            end
            OP_J: begin
                dec.pc_src = PC_JUMP;
            end
            OP_JAL: begin
                dec.pc_src  = PC_JUMP;
                dec.wa      = REG_RA;
                dec.reg_wen = 1'b1;
                dec.reg_src = RSRC_PC8;
            end
            default: ;
        endcase
        // $zero is never written, whatever the opcode says
        if (dec.wa == 5'd0)
            dec.reg_wen = 1'b0;
    end

    // Handshake and hazard qualification from registered state
    always_comb begin
        hazard = 1'b0;
        if (LOAD_USE_STALL != 0)
            hazard = ld_pend_q && held_valid_q &&
                     ((fld_q.ra1 == ld_wa_q) || (fld_q.rt_rd && (fld_q.ra2 == ld_wa_q)));
        out_valid = held_valid_q && !hazard;
        out_fire  = out_valid && bus.out_ready;
        in_ready  = !bus.flush && (!held_valid_q || out_fire);
        in_fire   = bus.in_valid && in_ready;
    end

    // Next-state: entry capture/release, load-use tracking, bubble counter
    always_comb begin
        fld_d        = fld_q;
        held_valid_d = held_valid_q;
        ld_pend_d    = 1'b0;
        ld_wa_d      = ld_wa_q;
        stall_cnt_d  = stall_cnt_q;
        if (hazard && (stall_cnt_q != {W_CNT{1'b1}}))
            stall_cnt_d = stall_cnt_q + W_CNT'(1);
        if (bus.flush) begin
            held_valid_d = 1'b0;
        end else begin
            if (in_fire) begin
                held_valid_d = 1'b1;
                fld_d        = dec;
            end else if (out_fire) begin
                held_valid_d = 1'b0;
            end
            if ((LOAD_USE_STALL != 0) && out_fire && fld_q.is_lw && (fld_q.wa != 5'd0)) begin
                ld_pend_d = 1'b1;
                ld_wa_d   = fld_q.wa;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fld_q        <= '0;
            held_valid_q <= 1'b0;
            ld_pend_q    <= 1'b0;
            ld_wa_q      <= '0;
            stall_cnt_q  <= '0;
        end else begin
            fld_q        <= fld_d;
            held_valid_q <= held_valid_d;
            ld_pend_q    <= ld_pend_d;
            ld_wa_q      <= ld_wa_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.pc_out    = fld_q.pc;
    assign bus.wa        = fld_q.wa;
    assign bus.ra1       = fld_q.ra1;
    assign bus.ra2       = fld_q.ra2;
    assign bus.reg_wen   = fld_q.reg_wen;
    assign bus.imm_out   = fld_q.imm;
    assign bus.sha       = fld_q.sha;
    assign bus.addr      = fld_q.addr;
    assign bus.alu_op    = fld_q.alu_op;
    assign bus.pc_src    = fld_q.pc_src;
    assign bus.mem_cmd   = fld_q.mem_cmd;
    assign bus.alu_src   = fld_q.alu_src;
    assign bus.reg_src   = fld_q.reg_src;
    assign bus.stall_cnt = stall_cnt_q;
endmodule
